uart_io: RTL and testbench

Byte-serial UART peripheral on the device side of the CPU's `irr`/`ack`/`rx_data` and `tx_req`/`tx_data`/`tx_busy` ports. The receiver deserialises the `uart_rx` pin, presents a byte on `rx_data` and raises `irr` until the CPU acknowledges it. The transmitter accepts a byte on a rising edge of `tx_req` and serialises it on `uart_tx`, holding `tx_busy` for the duration of the frame. The block sits at the top level between the CPU and the board pins. Frame format is fixed at 8N1.

---
 rtl/uart_io_pkg.sv | 21 ++
 rtl/uart_io_if.sv | 22 ++
 rtl/uart_io_tx_core.sv | 98 +++++++++
 rtl/uart_io.sv | 184 ++++++++++++++++++
 tb/tb_uart_io.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_io_pkg.sv
// Shared types and constants for the uart_io peripheral (8N1 UART).
package lib_uart;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } RX_STATE;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } TX_STATE;

endpackage

// File: rtl/uart_io_if.sv
// CPU-side handshake bundle of uart_io: receive interrupt/ack and transmit request/busy.
interface uart_io_if;
  import lib_uart::*;

  logic                      irr;
  logic                      ack;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      tx_req;
  logic [UART_DATA_BITS-1:0] tx_data;
  logic                      tx_busy;

  modport master (
    output ack, tx_req, tx_data,
    input  irr, rx_data, tx_busy
  );

  modport slave (
    input  ack, tx_req, tx_data,
    output irr, rx_data, tx_busy
  );

endinterface

// File: rtl/uart_io_tx_core.sv
// 8N1 transmitter: start bit, 8 data bits LSB first, stop bit, each CLKS_PER_BIT cycles.
module uart_tx_core
  import lib_uart::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [UART_DATA_BITS-1:0] data,
  output logic                      busy,
  output logic                      line
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  TX_STATE                   state_q, state_d;
  logic [CW-1:0]             baud_q, baud_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      line_q, line_d;
  logic                      busy_q, busy_d;
  logic                      bit_end;

  assign bit_end = (baud_q == BIT_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    line_d  = line_q;
    busy_d  = busy_q;
    unique case (state_q)
      TX_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (start) begin
          shift_d = data;
          line_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: begin
        if (bit_end) begin
          baud_d  = '0;
          line_d  = shift_q[0];
          state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          bit_d   = bit_q + 1'b1;
          shift_d = shift_q >> 1;
          if (bit_q == 3'(UART_DATA_BITS - 1)) begin
            line_d  = 1'b1;
            state_d = TX_STOP;
          end else begin
            line_d = shift_q[1];
          end
        end
      end
      TX_STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          busy_d  = 1'b0;
          state_d = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign line = line_q;

endmodule

// File: rtl/uart_io.sv
// 8N1 UART between CPU and board pins. Define UART_RX_FIFO_EN for a 4-entry receive FIFO
// instead of the single holding register.
module uart_io
  import lib_uart::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      uart_rx,
  output logic      uart_tx,
  uart_io_if.slave  cpu
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic ack_q, tx_req_q;
  logic ack_rise, tx_start, tx_busy;
  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q     <= 1'b0;
      tx_req_q  <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      ack_q     <= cpu.ack;
      tx_req_q  <= cpu.tx_req;
      rx_meta_q <= uart_rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign ack_rise = cpu.ack & ~ack_q;
  assign tx_start = cpu.tx_req & ~tx_req_q & ~tx_busy;

  uart_tx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_core (
    .clk   (clk),
    .reset (reset),
    .start (tx_start),
    .data  (cpu.tx_data),
    .busy  (tx_busy),
    .line  (uart_tx)
  );

  assign cpu.tx_busy = tx_busy;

  // Receiver
  RX_STATE                   rx_state_q, rx_state_d;
  logic [CW-1:0]             rx_baud_q, rx_baud_d;
  logic [2:0]                rx_bit_q, rx_bit_d;
  logic [UART_DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                      rx_ferr_q, rx_ferr_d;
  logic                      deliver;
  logic                      rx_bit_end;

  assign rx_bit_end = (rx_baud_q == BIT_LAST);

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q + 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_ferr_d  = rx_ferr_q;
    deliver    = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_baud_d = '0;
        rx_bit_d  = '0;
        rx_ferr_d = 1'b0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[UART_DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'(UART_DATA_BITS - 1)) rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // After a framing error, hold here until the line returns high.
        if (rx_ferr_q) begin
          rx_baud_d = '0;
          if (rx_sync_q) rx_state_d = RX_IDLE;
        end else if (rx_bit_end) begin
          rx_baud_d = '0;
          if (rx_sync_q) begin
            deliver    = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_d = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_ferr_q  <= rx_ferr_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  logic [UART_DATA_BITS-1:0] fifo_q [UART_FIFO_DEPTH];
  logic [1:0]                wptr_q, rptr_q;
  logic [2:0]                count_q;
  logic                      push, pop;

  assign push = deliver && (count_q != 3'(UART_FIFO_DEPTH));
  assign pop  = ack_rise && (count_q != 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(UART_FIFO_DEPTH); i++) fifo_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        fifo_q[wptr_q] <= rx_shift_q;
        wptr_q         <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
    end
  end

  assign cpu.irr     = (count_q != 3'd0);
  assign cpu.rx_data = fifo_q[rptr_q];
`else
  logic                      irr_q, irr_d;
  logic [UART_DATA_BITS-1:0] rx_data_q, rx_data_d;

  // A byte arriving while one is pending is dropped unless the ack edge frees the slot.
  always_comb begin
    irr_d     = irr_q;
    rx_data_d = rx_data_q;
    if (deliver && (!irr_q || ack_rise)) begin
      irr_d     = 1'b1;
      rx_data_d = rx_shift_q;
    end else if (ack_rise) begin
      irr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irr_q     <= 1'b0;
      rx_data_q <= '0;
    end else begin
      irr_q     <= irr_d;
      rx_data_q <= rx_data_d;
    end
  end

  assign cpu.irr     = irr_q;
  assign cpu.rx_data = rx_data_q;
`endif

endmodule

// File: tb/tb_uart_io.sv
// Scoreboard bench for uart_io at CLKS_PER_BIT=4: queues of expected RX/TX bytes, checked by monitors.
module tb_uart_io;
  import lib_uart::*;

  localparam int unsigned CPB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx;

  uart_io_if cpu_if ();

  uart_io #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .cpu     (cpu_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] rx_exp_q[$];
  logic [7:0] tx_exp_q[$];
  bit tx_abort = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic ack_pulse();
    cpu_if.ack = 1'b1;
    @(negedge clk);
    cpu_if.ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 100 && cpu_if.tx_busy; i++) @(negedge clk);
    check("tx_idle_timeout", {63'd0, cpu_if.tx_busy}, 64'd0);
  endtask

  // RX monitor: every rising irr must present the next expected byte.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_if.irr && !prev) begin
        if (rx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_unexpected: got byte %0h, expected no delivery", cpu_if.rx_data);
        end else begin
          check("rx_byte", {56'd0, cpu_if.rx_data}, {56'd0, rx_exp_q.pop_front()});
        end
      end
      prev = cpu_if.irr;
    end
  end

  // TX monitor: records uart_tx for every cycle of a busy window and checks the whole frame.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_if.tx_busy && !prev) begin
        logic [63:0] samp;
        logic [63:0] exp_samp;
        logic [9:0]  frame;
        logic [7:0]  b;
        int n;
        samp = '0;
        n = 0;
        while (cpu_if.tx_busy && n < 64) begin
          samp[n] = uart_tx;
          n++;
          @(negedge clk);
        end
        if (tx_abort) begin
          tx_abort = 1'b0;
        end else if (tx_exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected: got a frame of %0d cycles, expected none", n);
        end else begin
          b = tx_exp_q.pop_front();
          frame = {1'b1, b, 1'b0};
          exp_samp = '0;
          for (int i = 0; i < 40; i++) exp_samp[i] = frame[i / 4];
          check("tx_busy_len", 64'(n), 64'd40);
          check("tx_line", samp, exp_samp);
        end
      end
      prev = cpu_if.tx_busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    cpu_if.ack     = 1'b0;
    cpu_if.tx_req  = 1'b0;
    cpu_if.tx_data = 8'h00;

    // Reset
    repeat (3) @(negedge clk);
    check("rst_uart_tx", {63'd0, uart_tx}, 64'd1);
    check("rst_irr", {63'd0, cpu_if.irr}, 64'd0);
    check("rst_tx_busy", {63'd0, cpu_if.tx_busy}, 64'd0);
    check("rst_rx_data", {56'd0, cpu_if.rx_data}, 64'd0);
    reset = 1'b0;
    idle(2);

    // TX 0xA5 with tx_req held high
    tx_exp_q.push_back(8'hA5);
    cpu_if.tx_data = 8'hA5;
    cpu_if.tx_req  = 1'b1;
    check("tx_busy_before_edge", {63'd0, cpu_if.tx_busy}, 64'd0);
    @(negedge clk);
    check("tx_latency_busy", {63'd0, cpu_if.tx_busy}, 64'd1);
    check("tx_latency_line", {63'd0, uart_tx}, 64'd0);
    idle(50);
    check("tx_no_retrigger", {63'd0, cpu_if.tx_busy}, 64'd0);
    cpu_if.tx_req = 1'b0;
    idle(2);

    // TX 0x0F; a request edge during the frame is ignored
    tx_exp_q.push_back(8'h0F);
    cpu_if.tx_data = 8'h0F;
    cpu_if.tx_req  = 1'b1;
    @(negedge clk);
    cpu_if.tx_req = 1'b0;
    idle(8);
    cpu_if.tx_data = 8'hEE;
    cpu_if.tx_req  = 1'b1;
    @(negedge clk);
    cpu_if.tx_req = 1'b0;
    wait_tx_idle();
    idle(4);

    // RX 0x3C then acknowledge
    rx_exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    idle(6);
    check("rx_irr_set", {63'd0, cpu_if.irr}, 64'd1);
    cpu_if.ack = 1'b1;
    @(negedge clk);
    check("ack_clears_irr", {63'd0, cpu_if.irr}, 64'd0);
    idle(2);
    cpu_if.ack = 1'b0;
    idle(2);

    // Framing error, then a clean byte proves recovery
    send_rx(8'h55, 1'b0);
    idle(8);
    check("ferr_no_irr", {63'd0, cpu_if.irr}, 64'd0);
    rx_exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    idle(6);
    ack_pulse();

    // 1-cycle glitch
    uart_rx = 1'b0;
    @(negedge clk);
    uart_rx = 1'b1;
    idle(12);
    check("glitch_no_irr", {63'd0, cpu_if.irr}, 64'd0);

    // Overrun
    rx_exp_q.push_back(8'h11);
    send_rx(8'h11, 1'b1);
    idle(4);
    send_rx(8'h22, 1'b1);
    idle(6);
`ifdef UART_RX_FIFO_EN
    send_rx(8'h33, 1'b1);
    idle(4);
    send_rx(8'h44, 1'b1);
    idle(4);
    send_rx(8'h66, 1'b1);
    idle(6);
    check("fifo_head0", {56'd0, cpu_if.rx_data}, 64'h11);
    ack_pulse();
    check("fifo_head1", {56'd0, cpu_if.rx_data}, 64'h22);
    ack_pulse();
    check("fifo_head2", {56'd0, cpu_if.rx_data}, 64'h33);
    ack_pulse();
    check("fifo_head3", {56'd0, cpu_if.rx_data}, 64'h44);
    check("fifo_irr_last", {63'd0, cpu_if.irr}, 64'd1);
    ack_pulse();
    check("fifo_empty", {63'd0, cpu_if.irr}, 64'd0);
`else
    check("overrun_keep", {56'd0, cpu_if.rx_data}, 64'h11);
    check("overrun_irr", {63'd0, cpu_if.irr}, 64'd1);
    ack_pulse();
    check("overrun_ack", {63'd0, cpu_if.irr}, 64'd0);
`endif
    idle(4);

    // Reset during TX data bits
    tx_abort = 1'b1;
    cpu_if.tx_data = 8'h00;
    cpu_if.tx_req  = 1'b1;
    idle(14);
    reset = 1'b1;
    cpu_if.tx_req = 1'b0;
    @(negedge clk);
    check("rst_mid_tx_line", {63'd0, uart_tx}, 64'd1);
    check("rst_mid_tx_busy", {63'd0, cpu_if.tx_busy}, 64'd0);
    reset = 1'b0;
    idle(4);

    // Reset during RX data bits
    fork
      send_rx(8'hFF, 1'b1);
      begin
        idle(16);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end
    join
    idle(12);
    check("rst_mid_rx_irr", {63'd0, cpu_if.irr}, 64'd0);

    check("rx_queue_drained", 64'(rx_exp_q.size()), 64'd0);
    check("tx_queue_drained", 64'(tx_exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
